imem_loader_ctrl: RTL and testbench

- Sequences writes into the single-cycle CPU's instruction memory: it takes a byte stream over a valid/ready handshake, packs four bytes into each 32-bit word and issues one write per word.
- Holds the CPU in stall while a program is being loaded, then releases it.
- Sits between the host/debug byte source and the instruction memory write port; the CPU fetch path (pc_address[11:2]) is untouched.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader_ctrl.sv | 125 ++++++++++++
 tb/tb_imem_loader_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream, load-control and instruction-memory write signals of the IMEM loader.
// master = host/debug side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_base, load_words, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_hold, load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, load_base, load_words, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_hold, load_busy, load_done, load_err
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory
// while holding the CPU. Define IMEM_LOADER_CHECKSUM_EN to verify a trailing 32-bit sum.
module imem_loader_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   words_q, wcnt;
  logic [1:0]        bcnt;
  logic [31:0]       word;
  logic              cpu_hold, load_err;
  logic              byte_ready, im_we, load_busy, load_done;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic [ADDR_W+1:0] end_addr;
  logic              bad_len, start_acc, byte_fire, last_byte, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum;
  logic              chk_ok;
`endif

  // Range check is done once at start so the write address can never wrap.
  assign end_addr  = {2'b00, bus.load_base} + {1'b0, bus.load_words};
  assign bad_len   = (bus.load_words == '0) || ({1'b0, bus.load_words} > DEPTH_L) ||
                     (end_addr > DEPTH_L);
  assign start_acc = (state == IDLE) && bus.load_start;
  assign byte_fire = bus.byte_valid && byte_ready;
  assign last_byte = byte_fire && (bcnt == 2'd3);
  assign last_word = (wcnt + (ADDR_W+1)'(1)) == words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_ok    = ({bus.byte_data, word[31:8]} == sum);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_acc && !bad_len) next_state = RECV;
      RECV:  if (last_byte) next_state = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE: next_state = last_word ? CHK : RECV;
      CHK:   if (last_byte) next_state = chk_ok ? DONE : IDLE;
`else
      WRITE: next_state = last_word ? DONE : RECV;
`endif
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    im_we      = 1'b0;
    im_waddr   = '0;
    im_wdata   = '0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state)
      RECV:  begin byte_ready = 1'b1; load_busy = 1'b1; end
      WRITE: begin im_we = 1'b1; im_waddr = addr; im_wdata = word; load_busy = 1'b1; end
      CHK:   begin byte_ready = 1'b1; load_busy = 1'b1; end
      DONE:  load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      words_q  <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      load_err <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      cpu_hold <= (next_state == RECV) || (next_state == WRITE) || (next_state == CHK);
      if (start_acc) begin
        addr     <= bus.load_base;
        words_q  <= bus.load_words;
        wcnt     <= '0;
        bcnt     <= '0;
        load_err <= bad_len;
      end else if (state == WRITE) begin
        addr <= addr + ADDR_W'(1);
        wcnt <= wcnt + (ADDR_W+1)'(1);
        bcnt <= '0;
      end else if (byte_fire) begin
        bcnt <= bcnt + 2'd1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CHK && last_byte && !chk_ok) load_err <= 1'b1;
`endif
    end
  end

  // Datapath: shift-in packing puts the first byte of a word in [7:0] after four shifts.
  always_ff @(posedge clk) begin
    if (byte_fire) word <= {bus.byte_data, word[31:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (start_acc)            sum <= '0;
    else if (state == WRITE)  sum <= sum + word;
`endif
  end

  assign bus.byte_ready = byte_ready;
  assign bus.im_we      = im_we;
  assign bus.im_waddr   = im_waddr;
  assign bus.im_wdata   = im_wdata;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.load_busy  = load_busy;
  assign bus.load_done  = load_done;
  assign bus.load_err   = load_err;
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scenario bench for imem_loader_ctrl: expected memory writes are queued as stimulus is driven.
module tb_imem_loader_ctrl;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader_ctrl #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  logic [41:0] exp_q[$];
  logic [41:0] act_q[$];
  int cyc = 0, first_cyc = -1, done_cyc = -1, done_cnt = 0;
  bit hold_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.im_we) act_q.push_back({bus.im_waddr, bus.im_wdata});
    if (bus.load_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.cpu_hold) hold_seen = 1'b1;
    if (bus.byte_valid && bus.byte_ready && first_cyc < 0) first_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input logic [9:0] base, input logic [10:0] words);
    bus.load_base = base; bus.load_words = words; bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bubble);
    int t = 0;
    bus.byte_valid = 1'b1; bus.byte_data = b;
    forever begin
      @(negedge clk);
      if (bus.byte_ready) break;
      t++;
      if (t > 50) begin
        n_chk++;
        $display("FAIL byte_accept: byte_ready=%b for %0d cycles, required 1", bus.byte_ready, t);
        break;
      end
    end
    tick();
    bus.byte_valid = 1'b0;
    if (bubble) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit bubble);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], bubble);
  endtask

  task automatic send_sum(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s, 1'b0);
`else
    if (s === 32'hx) $display("note: unexpected unknown sum");
`endif
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (bus.load_busy && t < 200);
    if (bus.load_busy) begin
      n_chk++;
      $display("FAIL wait_idle: load_busy=%b after %0d cycles, required 0", bus.load_busy, t);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.cpu_hold, bus.load_busy, bus.load_done, bus.load_err, bus.byte_ready, bus.im_we} !== 6'b0)
      $display("FAIL reset_ctrl: outputs=%b required 000000", {bus.cpu_hold, bus.load_busy,
               bus.load_done, bus.load_err, bus.byte_ready, bus.im_we});
    else n_pass++;
    n_chk++;
    if (bus.im_waddr !== 10'd0 || bus.im_wdata !== 32'd0)
      $display("FAIL reset_bus: addr=%0d data=%h required 0/0", bus.im_waddr, bus.im_wdata);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b0)
      $display("FAIL idle_after_reset: ready=%b hold=%b required 0/0", bus.byte_ready, bus.cpu_hold);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] bb [8] = '{8'h13, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'h08, 8'h24};
    logic [41:0] e, a;
    int lat;
    first_cyc = -1; done_cnt = 0;
    exp_q.push_back({10'd0, 32'h20080013});
    exp_q.push_back({10'd1, 32'h2408FFFF});
    start_load(10'd0, 11'd2);
    n_chk++;
    if (bus.cpu_hold !== 1'b1 || bus.load_busy !== 1'b1)
      $display("FAIL basic_hold: hold=%b busy=%b required 1/1", bus.cpu_hold, bus.load_busy);
    else n_pass++;
    for (int i = 0; i < 8; i++) send_byte(bb[i], 1'b0);
    send_sum(32'h20080013 + 32'h2408FFFF);
    wait_idle();
    n_chk++;
    if (act_q.size() != exp_q.size())
      $display("FAIL basic_wcount: writes=%0d required=%0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 42'hx;
      n_chk++;
      if (a !== e) $display("FAIL basic_write: got addr=%0d data=%h required addr=%0d data=%h",
                            a[41:32], a[31:0], e[41:32], e[31:0]);
      else n_pass++;
    end
    act_q.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
    lat = 14;
`else
    lat = 10;
`endif
    n_chk++;
    if (done_cnt != 1 || done_cyc - first_cyc != lat)
      $display("FAIL basic_done: pulses=%0d latency=%0d required 1/%0d", done_cnt, done_cyc - first_cyc, lat);
    else n_pass++;
    n_chk++;
    if (bus.cpu_hold !== 1'b0 || bus.load_err !== 1'b0)
      $display("FAIL basic_release: hold=%b err=%b required 0/0", bus.cpu_hold, bus.load_err);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    logic [31:0] w = 32'hDEADBEEF;
    logic [41:0] e, a;
    bit ready_ok = 1'b1;
    exp_q.push_back({10'd5, w});
    start_load(10'd5, 11'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b0);
      if (i < 3) begin
        @(negedge clk);
        if (bus.byte_ready !== 1'b1) ready_ok = 1'b0;
        tick();
      end
    end
    send_sum(w);
    wait_idle();
    n_chk++;
    if (!ready_ok) $display("FAIL bubble_ready: byte_ready dropped in a bubble, required 1");
    else n_pass++;
    n_chk++;
    if (act_q.size() != exp_q.size())
      $display("FAIL bubble_wcount: writes=%0d required=%0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 42'hx;
      n_chk++;
      if (a !== e) $display("FAIL bubble_write: got addr=%0d data=%h required addr=%0d data=%h",
                            a[41:32], a[31:0], e[41:32], e[31:0]);
      else n_pass++;
    end
    act_q.delete();
  endtask

  task automatic test_bad_len();
    logic [41:0] e, a;
    hold_seen = 1'b0;
    start_load(10'd0, 11'd0);
    n_chk++;
    if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.load_busy !== 1'b0)
      $display("FAIL badlen_zero: err=%b hold=%b busy=%b required 1/0/0",
               bus.load_err, bus.cpu_hold, bus.load_busy);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (hold_seen !== 1'b0 || act_q.size() != 0)
      $display("FAIL badlen_quiet: hold_seen=%b writes=%0d required 0/0", hold_seen, act_q.size());
    else n_pass++;
    start_load(10'd1020, 11'd8);
    n_chk++;
    if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b0)
      $display("FAIL badlen_range: err=%b hold=%b required 1/0", bus.load_err, bus.cpu_hold);
    else n_pass++;
    start_load(10'd0, 11'd1025);
    n_chk++;
    if (bus.load_err !== 1'b1)
      $display("FAIL badlen_depth: err=%b required 1", bus.load_err);
    else n_pass++;
    // Last legal word: base 1023, one word.
    exp_q.push_back({10'd1023, 32'hCAFEF00D});
    start_load(10'd1023, 11'd1);
    n_chk++;
    if (bus.load_err !== 1'b0 || bus.load_busy !== 1'b1)
      $display("FAIL edge_start: err=%b busy=%b required 0/1", bus.load_err, bus.load_busy);
    else n_pass++;
    send_word(32'hCAFEF00D, 1'b0);
    send_sum(32'hCAFEF00D);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 42'hx;
      n_chk++;
      if (a !== e) $display("FAIL edge_write: got addr=%0d data=%h required addr=%0d data=%h",
                            a[41:32], a[31:0], e[41:32], e[31:0]);
      else n_pass++;
    end
    act_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [41:0] e, a;
    exp_q.push_back({10'd10, 32'h44332211});
    start_load(10'd10, 11'd3);
    send_word(32'h44332211, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.cpu_hold, bus.load_busy, bus.load_done, bus.load_err, bus.byte_ready, bus.im_we} !== 6'b0)
      $display("FAIL midreset_out: outputs=%b required 000000", {bus.cpu_hold, bus.load_busy,
               bus.load_done, bus.load_err, bus.byte_ready, bus.im_we});
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (act_q.size() != exp_q.size())
      $display("FAIL midreset_wcount: writes=%0d required=%0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 42'hx;
      n_chk++;
      if (a !== e) $display("FAIL midreset_write: got addr=%0d data=%h required addr=%0d data=%h",
                            a[41:32], a[31:0], e[41:32], e[31:0]);
      else n_pass++;
    end
    act_q.delete();
    done_cnt = 0;
    exp_q.push_back({10'd20, 32'h0BADC0DE});
    start_load(10'd20, 11'd1);
    send_word(32'h0BADC0DE, 1'b0);
    send_sum(32'h0BADC0DE);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 42'hx;
      n_chk++;
      if (a !== e) $display("FAIL reload_write: got addr=%0d data=%h required addr=%0d data=%h",
                            a[41:32], a[31:0], e[41:32], e[31:0]);
      else n_pass++;
    end
    act_q.delete();
    n_chk++;
    if (done_cnt != 1) $display("FAIL reload_done: pulses=%0d required 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_ignored_restart();
    logic [31:0] w0 = 32'h87654321;
    logic [31:0] w1 = 32'h0F1E2D3C;
    logic [41:0] e, a;
    done_cnt = 0;
    exp_q.push_back({10'd100, w0});
    exp_q.push_back({10'd101, w1});
    start_load(10'd100, 11'd2);
    send_byte(w0[7:0], 1'b0);
    send_byte(w0[15:8], 1'b0);
    bus.load_base = 10'd200; bus.load_words = 11'd1; bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    send_byte(w0[23:16], 1'b0);
    send_byte(w0[31:24], 1'b0);
    send_word(w1, 1'b0);
    send_sum(w0 + w1);
    wait_idle();
    n_chk++;
    if (act_q.size() != exp_q.size())
      $display("FAIL restart_wcount: writes=%0d required=%0d", act_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 42'hx;
      n_chk++;
      if (a !== e) $display("FAIL restart_write: got addr=%0d data=%h required addr=%0d data=%h",
                            a[41:32], a[31:0], e[41:32], e[31:0]);
      else n_pass++;
    end
    act_q.delete();
    n_chk++;
    if (done_cnt != 1 || bus.load_err !== 1'b0)
      $display("FAIL restart_done: pulses=%0d err=%b required 1/0", done_cnt, bus.load_err);
    else n_pass++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    done_cnt = 0;
    start_load(10'd0, 11'd2);
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00000003, 1'b0);
    wait_idle();
    n_chk++;
    if (done_cnt != 1 || bus.load_err !== 1'b0)
      $display("FAIL chk_match: pulses=%0d err=%b required 1/0", done_cnt, bus.load_err);
    else n_pass++;
    n_chk++;
    if (act_q.size() != 2) $display("FAIL chk_match_writes: writes=%0d required 2", act_q.size());
    else n_pass++;
    act_q.delete();
    done_cnt = 0;
    start_load(10'd0, 11'd2);
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00000004, 1'b0);
    wait_idle();
    n_chk++;
    if (done_cnt != 0 || bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b0)
      $display("FAIL chk_mismatch: pulses=%0d err=%b hold=%b required 0/1/0",
               done_cnt, bus.load_err, bus.cpu_hold);
    else n_pass++;
    act_q.delete();
  endtask
`endif

  initial begin
    bus.load_start = 1'b0; bus.load_base = '0; bus.load_words = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_bad_len();
    test_reset_mid();
    test_ignored_restart();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
